// File: rtl/nibble_serial_subtractor_if.sv
// Request/response bundle for the nibble-serial subtractor.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface nibble_serial_subtractor_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, overflow
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, overflow
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Computes a - b - bin one 4-bit slice per cycle, LSB slice first, using a carry-lookahead slice adder.
// Operands shift right each cycle and the partial difference is shifted in from the top.
module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_subtractor_if.slave  bus,
  output logic [1:0]                 dbg_state_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  work_q, work_d, diff_q, diff_d;
  logic          borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [3:0]    s_a, s_bn, g, p, s_sum;
  logic [4:0]    c;
  logic [W-1:0]  sum_w, work_shift;

  // Slice adder: a + ~b + ~borrow, carries resolved by lookahead within the slice.
  always_comb begin
    s_a   = a_q[3:0];
    s_bn  = ~b_q[3:0];
    g     = s_a & s_bn;
    p     = s_a ^ s_bn;
    c[0]  = ~borrow_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_sum = p ^ c[3:0];
    sum_w      = W'(s_sum);
    work_shift = (work_q >> 4) | (sum_w << (W - 4));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          work_d   = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        borrow_d = ~c[4];
        work_d   = work_shift;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IW'(NIBBLES - 1)) begin
          idx_d   = '0;
          state_d = DONE;
          diff_d  = work_shift;
          bout_d  = ~c[4];
          // a_q[3]/b_q[3] now hold the original sign bits.
          ovf_d   = (a_q[3] ^ b_q[3]) & (s_sum[3] ^ a_q[3]);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed vectors, backpressure, mid-operation reset,
// back-to-back throughput and random traffic, all checked against an expected-result queue.
module tb_nibble_serial_subtractor;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  nibble_serial_subtractor_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Scoreboard state
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [W+1:0]  exp_q[$];
  int            acc_q[$];
  bit            seen_valid = 1'b0;
  bit            thr_mode   = 1'b0;
  bit            have_last  = 1'b0;
  bit            rnd_ready  = 1'b0;
  int            last_acc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: {bout, overflow, diff} from plain wide arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    int         sv;
    logic       ovf;
    full = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    sv   = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ovf  = (sv < -(1 << (W - 1))) || (sv > (1 << (W - 1)) - 1);
    return {full[W], ovf, full[W-1:0]};
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.bin));
        acc_q.push_back(cyc + 1);
        if (thr_mode) begin
          if (have_last) check("period", cyc - last_acc, 6);
          last_acc  = cyc;
          have_last = 1'b1;
        end
      end
      if (bus.out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (acc_q.size() > 0) check("latency", cyc - acc_q[0], NIBBLES);
      end
      if (!bus.out_valid) seen_valid = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          check("result", {bus.bout, bus.overflow, bus.diff}, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int k = 0;
    while (!bus.in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.bin      = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(posedge clk); #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      k++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    bus.out_ready = 1'b1;
  endtask

  task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                     input logic [W-1:0] ed, input logic eb, input logic eo);
    send(a, b, bin);
    drain();
    check("dir_hold", {bus.bout, bus.overflow, bus.diff}, {eb, eo, ed});
  endtask

  initial begin
    logic [W+1:0] e;
    int           k;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_state", dbg_state, 0);

    bus.out_ready = 1'b1;
    dir(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    dir(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    dir(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    dir(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    dir(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    dir(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    dir(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);

    // Backpressure with a competing request held on the input.
    bus.out_ready = 1'b0;
    e = model(16'hA5A5, 16'h5A5A, 1'b1);
    send(16'hA5A5, 16'h5A5A, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_reach_done", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h0001;
    bus.bin      = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold", {bus.bout, bus.overflow, bus.diff}, e);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", bus.in_ready, 1);
    check("bp_idle_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    check("bp_second", {bus.bout, bus.overflow, bus.diff}, {2'b00, 16'h1110});

    // Reset two cycles after an accept.
    send(16'hFFFF, 16'h0F0F, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    seen_valid = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_outputs", {bus.bout, bus.overflow, bus.diff}, 0);
    dir(16'h2000, 16'h1001, 1'b1, 16'h0FFE, 1'b0, 1'b0);

    // Back-to-back throughput with fresh operands every cycle.
    thr_mode      = 1'b1;
    have_last     = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    repeat (40) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    thr_mode     = 1'b0;
    drain();

    // Random traffic with random consumer stalls.
    rnd_ready = 1'b1;
    repeat (15) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      drain();
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
